// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding,
// instruction geometry and a canonical NOP.
package if_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

    localparam int INSTR_BYTES = 4;

    // RISC-V "addi x0, x0, 0"
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, keeps one instruction-memory request in flight and
// hands each returned word, tagged with its pointer, to the IF/ID register.
module instruction_fetch_unit
    import if_pkg::*;
#(
    parameter int INSTRUCTION_LEN = 32,
    parameter int ADDRESS_SIZE    = 6,
    localparam int PTR_W          = 2 ** ADDRESS_SIZE,
    parameter logic [PTR_W-1:0] RESET_VECTOR = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       PC_WRITE,
    input  logic                       PC_SRC,
    input  logic [PTR_W-1:0]           branch_target,
    output logic                       imem_req,
    output logic [ADDRESS_SIZE-1:0]    imem_addr,
    input  logic                       imem_rvalid,
    input  logic [INSTRUCTION_LEN-1:0] imem_rdata,
    output logic [INSTRUCTION_LEN-1:0] instruction_out,
    output logic [PTR_W-1:0]           instruction_ptr_out,
    output logic                       IF_ID_WRITE,
    output logic                       IF_FLUSH
);

    fetch_state_t               state, state_next;
    logic [PTR_W-1:0]           pc, pc_next;
    logic                       kill, kill_next;
    logic [INSTRUCTION_LEN-1:0] hold_buf, hold_buf_next;
    logic [PTR_W-1:0]           pc_plus4;

    assign pc_plus4 = pc + PTR_W'(INSTR_BYTES);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            pc       <= RESET_VECTOR;
            kill     <= 1'b0;
            hold_buf <= '0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            kill     <= kill_next;
            hold_buf <= hold_buf_next;
        end
    end

    // A redirect always wins; a response that raced a redirect is tagged by
    // kill so it can be swallowed without ever reaching IF/ID.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        kill_next       = kill;
        hold_buf_next   = hold_buf;
        imem_req        = 1'b0;
        IF_ID_WRITE     = 1'b0;
        instruction_out = '0;

        case (state)
            IDLE: begin
                state_next = FETCH;
            end

            FETCH: begin
                if (PC_SRC) begin
                    pc_next = branch_target;
                end else begin
                    imem_req   = 1'b1;
                    state_next = WAIT;
                end
            end

            WAIT: begin
                if (imem_rvalid) begin
                    if (kill || PC_SRC) begin
                        kill_next  = 1'b0;
                        state_next = FETCH;
                        if (PC_SRC) begin
                            pc_next = branch_target;
                        end
                    end else if (PC_WRITE) begin
                        IF_ID_WRITE     = 1'b1;
                        instruction_out = imem_rdata;
                        pc_next         = pc_plus4;
                        state_next      = FETCH;
                    end else begin
                        hold_buf_next = imem_rdata;
                        state_next    = HOLD;
                    end
                end else if (PC_SRC) begin
                    pc_next   = branch_target;
                    kill_next = 1'b1;
                end
            end

            HOLD: begin
                if (PC_SRC) begin
                    pc_next    = branch_target;
                    state_next = FETCH;
                end else if (PC_WRITE) begin
                    IF_ID_WRITE     = 1'b1;
                    instruction_out = hold_buf;
                    pc_next         = pc_plus4;
                    state_next      = FETCH;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Flush is combinational so the wrong-path IF/ID entry dies on this edge.
    assign IF_FLUSH            = PC_SRC && (state != IDLE);
    assign imem_addr           = pc[ADDRESS_SIZE+1:2];
    assign instruction_ptr_out = pc;

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage that owns the program counter, issues one-outstanding requests to the instruction memory, and presents each returned instruction with its pointer to the IF/ID pipeline register. It sits directly upstream of `IF_ID_PIPELINE` and drives that block's `instruction_in`, `instruction_ptr_in`, `IF_FLUSH` and `IF_ID_WRITE`. It honours the hazard unit's stall (`PC_WRITE`) and the EX-stage branch redirect (`PC_SRC`).

## Interface
Parameters:
- `INSTRUCTION_LEN`, 32, instruction width in bits.
- `ADDRESS_SIZE`, 6, log2 of instruction memory depth in words. Pointer width is `PTR_W = 2**ADDRESS_SIZE`.
- `RESET_VECTOR`, 0, byte pointer fetched first after reset.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `PC_WRITE`  in  1  1 = IF/ID may accept; 0 = stall from the hazard unit.
- `PC_SRC`  in  1  branch/jump taken this cycle; redirect to `branch_target`.
- `branch_target`  in  PTR_W  redirect byte pointer.
- `imem_req`  out  1  single-cycle fetch request pulse.
- `imem_addr`  out  ADDRESS_SIZE  word address, `pc[ADDRESS_SIZE+1:2]`.
- `imem_rvalid`  in  1  response valid; exactly one per request, 1 or more cycles after it.
- `imem_rdata`  in  INSTRUCTION_LEN  instruction word, valid with `imem_rvalid`.
- `instruction_out`  out  INSTRUCTION_LEN  to `IF_ID_PIPELINE.instruction_in`.
- `instruction_ptr_out`  out  PTR_W  to `IF_ID_PIPELINE.instruction_ptr_in`.
- `IF_ID_WRITE`  out  1  load strobe for IF/ID.
- `IF_FLUSH`  out  1  squash IF/ID contents.

## Operation
- Registers: `pc` (PTR_W), `state`, `kill` (1), `hold_buf` (INSTRUCTION_LEN).
- States: IDLE, FETCH, WAIT, HOLD.
  - **IDLE.** Entered only by reset. Moves to FETCH on the next edge.
  - **FETCH.** `imem_req=1` and `imem_addr` is taken from `pc`. Moves to WAIT. If `PC_SRC` is high: load `pc<=branch_target` and stay in FETCH. No request is issued in that cycle.
  - **WAIT with `imem_rvalid=1`.**
    - If `kill` or `PC_SRC` is set: discard the data, clear `kill` and go to FETCH. On `PC_SRC`, also load `pc<=branch_target`.
    - Otherwise, if `PC_WRITE=1`: `IF_ID_WRITE=1`, `instruction_out=imem_rdata`, `pc<=pc+4`, go to FETCH.
    - Otherwise: `hold_buf<=imem_rdata`, go to HOLD.
  - **WAIT with `imem_rvalid=0` and `PC_SRC=1`.** Load `pc<=branch_target`, set `kill<=1`, stay in WAIT. The stale response is dropped when it arrives.
  - **HOLD with `PC_SRC=1`.** Drop `hold_buf`, load `pc<=branch_target`, go to FETCH.
  - **HOLD with `PC_WRITE=1`.** `IF_ID_WRITE=1`, `instruction_out=hold_buf`, `pc<=pc+4`, go to FETCH. If `PC_WRITE=0`, stay in HOLD.
- `PC_SRC` takes priority over `PC_WRITE` and `imem_rvalid` in every state.
- `IF_FLUSH = PC_SRC` in every state except IDLE. It is combinational, so the wrong-path IF/ID entry is squashed on the same edge.
- `instruction_ptr_out = pc`. `pc` advances only when an instruction is accepted, so the pointer always matches the presented instruction.
- `instruction_out` is forced to 0 whenever `IF_ID_WRITE=0`.
- Arithmetic: `pc+4` is modulo 2^PTR_W. `imem_addr` wraps naturally at the memory depth. `pc[1:0]` is ignored for addressing.
- At most one request is outstanding. `imem_rvalid` seen outside WAIT is ignored.

## Timing
- Reset values: state=IDLE, `pc=RESET_VECTOR`, `kill=0`, `hold_buf=0`. Outputs are `imem_req=0`, `IF_ID_WRITE=0`, `IF_FLUSH=0`, `instruction_out=0`, `instruction_ptr_out=RESET_VECTOR`.
- After `rst` deasserts, the first `imem_req` is seen in the second cycle.
- With 1-cycle memory latency and no stalls, there is one `IF_ID_WRITE` every 2 cycles (FETCH, WAIT).
- From the `PC_SRC` cycle to the request at the target:
  - 1 cycle from FETCH or HOLD.
  - From WAIT: the cycle after the stale response arrives.
- `rst` asserted mid-operation aborts immediately, with no response pending bookkeeping. The bench must not return a response from before reset.

## Structure
- Shared package `if_pkg`:
  - `fetch_state_t` enum (IDLE, FETCH, WAIT, HOLD).
  - `INSTR_BYTES=4`.
  - `NOP_INSTR` constant for bench use.
- No sub-module; single module with one FSM `always_ff`, one next-state/output `always_comb`.

## Test plan
- **Reset release.** `rst` goes 0→1 with `RESET_VECTOR=0` → `imem_req` pulses with `imem_addr=0` on the 2nd cycle. All outputs are 0 before that.
- **Straight-line fetch.** 1-cycle memory returning `32'h00000013`, `32'h00100093`, `PC_WRITE=1` → `IF_ID_WRITE` every other cycle. Ptr sequence is 0, 4, 8.
- **Stall.** Hold `PC_WRITE=0` for 5 cycles when a response arrives → state HOLD, `IF_ID_WRITE=0`, no new `imem_req`. On release, the buffered word is written once with an unchanged pointer.
- **Redirect during WAIT.** 3-cycle memory; `PC_SRC=1` with `branch_target=64'h40` one cycle after the request → `IF_FLUSH=1` that cycle. The stale response is dropped. The next request has `imem_addr=16`, and the next written ptr is `0x40`.
- **Simultaneous events.** `PC_SRC`, `imem_rvalid` and `PC_WRITE` all high in one cycle → no `IF_ID_WRITE`, `IF_FLUSH=1`, next fetch at the target.
- **Wrap.** `branch_target=PTR_W'(-4)` → instruction written with that pointer. The next pointer is 0 and `imem_addr` wraps to 0.
